// File: rtl/game_state_ctrl.sv
// Game flow controller for the brick-breaker game.
// Tracks lives and remaining bricks, sequences IDLE/PLAY/RESPAWN/WIN/LOSE,
// and tells the movers when to freeze.
// Every output is a flop loaded from the next-state logic, so each one
// changes one clock after the input that caused the change.
module game_state_ctrl #(
  parameter int INIT_LIVES     = 3,
  parameter int NUM_BRICKS     = 40,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_game,
  input  logic       startOfFrame,
  input  logic       brick_hit,
  input  logic       ball_lost,
  output logic       win,
  output logic [3:0] lives,
  output logic [6:0] bricks_left,
  output logic       game_active,
  output logic       freeze
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_RESPAWN,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [3:0] LIVES_INIT   = 4'(INIT_LIVES);
  localparam logic [6:0] BRICKS_INIT  = 7'(NUM_BRICKS);
  localparam logic [7:0] FRAMES_LIMIT = 8'(RESPAWN_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [6:0] bricks_q, bricks_d;
  logic [7:0] frame_q, frame_d;
  logic       win_q, active_q, freeze_q;

  // Saturating decrements and frame increment shared by the next-state logic
  logic [3:0] lives_dec;
  logic [6:0] bricks_dec;
  logic [7:0] frame_inc;

  // Next-state and next-counter logic; everything holds unless a rule fires
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    bricks_d   = bricks_q;
    frame_d    = frame_q;
    lives_dec  = (ball_lost && lives_q != 4'd0)  ? lives_q - 4'd1  : lives_q;
    bricks_dec = (brick_hit && bricks_q != 7'd0) ? bricks_q - 7'd1 : bricks_q;
    frame_inc  = frame_q + 8'd1;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_game) begin
          state_d  = S_PLAY;
          lives_d  = LIVES_INIT;
          bricks_d = BRICKS_INIT;
        end
      end
      S_PLAY: begin
        bricks_d = bricks_dec;
        if (brick_hit && bricks_dec == 7'd0) begin
          // Clearing the last brick wins even if the ball is lost in the
          // same cycle. The life is still spent, but never down to zero:
          // lives==0 is the lose banner and must not appear beside a win.
          state_d = S_WIN;
          if (lives_dec != 4'd0) lives_d = lives_dec;
        end else if (ball_lost) begin
          lives_d = lives_dec;
          frame_d = 8'd0;
          state_d = (lives_dec == 4'd0) ? S_LOSE : S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        if (startOfFrame) begin
          frame_d = frame_inc;
          if (frame_inc == FRAMES_LIMIT) state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered status outputs; async reset abandons any game
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      lives_q  <= LIVES_INIT;
      bricks_q <= BRICKS_INIT;
      frame_q  <= 8'd0;
      win_q    <= 1'b0;
      active_q <= 1'b0;
      freeze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      bricks_q <= bricks_d;
      frame_q  <= frame_d;
      win_q    <= (state_d == S_WIN);
      active_q <= (state_d == S_PLAY);
      freeze_q <= (state_d != S_PLAY);
    end
  end

  assign win         = win_q;
  assign lives       = lives_q;
  assign bricks_left = bricks_q;
  assign game_active = active_q;
  assign freeze      = freeze_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter INIT_LIVES, default 3, lives loaded at game start (range 1..15).
REQ-002 SHALL have parameter NUM_BRICKS, default 40, bricks loaded at game start (range 1..127).
REQ-003 SHALL have parameter RESPAWN_FRAMES, default 60, frame ticks of freeze after a lost ball (range 1..255).
REQ-004 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-005 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_game, input, 1, one-cycle pulse from key press requesting a new game.
REQ-007 SHALL have port startOfFrame, input, 1, one-cycle pulse once per video frame.
REQ-008 SHALL have port brick_hit, input, 1, one-cycle pulse per destroyed brick.
REQ-009 SHALL have port ball_lost, input, 1, one-cycle pulse when the ball exits below the paddle.
REQ-010 SHALL have port win, output, 1, high while in WIN; drives result screen win input.
REQ-011 SHALL have port lives, output, 4, remaining lives; drives result screen lose input (0 shows lose banner).
REQ-012 SHALL have port bricks_left, output, 7, remaining bricks.
REQ-013 SHALL have port game_active, output, 1, high in PLAY only.
REQ-014 SHALL have port freeze, output, 1, high in every state except PLAY; ball/paddle movers hold position when high.

Function
REQ-015 SHALL implement states IDLE, PLAY, RESPAWN, WIN, LOSE; all outputs registered, update one clock after the causing input.
REQ-016 IDLE: start_game -> PLAY, loading lives=INIT_LIVES, bricks_left=NUM_BRICKS; brick_hit, ball_lost ignored.
REQ-017 PLAY: brick_hit decrements bricks_left by 1; when decrement yields 0 -> WIN in the same edge.
REQ-018 PLAY: ball_lost decrements lives by 1; result 0 -> LOSE, else -> RESPAWN with frame counter cleared.
REQ-019 PLAY: brick_hit and ball_lost in the same cycle: both counters decrement; if bricks_left reaches 0 -> WIN takes priority over LOSE/RESPAWN.
REQ-020 PLAY: start_game ignored.
REQ-021 RESPAWN: frame counter increments on each startOfFrame; on the tick that makes count equal RESPAWN_FRAMES -> PLAY; brick_hit, ball_lost, start_game ignored.
REQ-022 WIN: win=1, counters held; start_game -> PLAY with both counters reloaded and win=0.
REQ-023 LOSE: lives=0, win=0; start_game -> PLAY with both counters reloaded.
REQ-024 lives and bricks_left SHALL saturate at 0, never wrap.
REQ-025 win and lives=0 SHALL never be asserted simultaneously.
REQ-026 Frame counter 8 bits wide, compared unsigned; no wrap before match.

Reset
REQ-027 On resetN low, asynchronously: state=IDLE, lives=INIT_LIVES, bricks_left=NUM_BRICKS, win=0, game_active=0, freeze=1, frame counter=0.
REQ-028 Reset asserted mid-game (any state) SHALL abandon the game and return to IDLE values above; no pending pulse survives reset.

Verification
REQ-029 Reset, start_game pulse -> next cycle game_active=1, freeze=0, lives=3, bricks_left=40.
REQ-030 In PLAY, 40 brick_hit pulses -> bricks_left 40..0, win=1, freeze=1 one cycle after 40th pulse; start_game -> win=0, bricks_left=40, lives=3.
REQ-031 In PLAY, ball_lost -> lives=2, freeze=1; exactly 60 startOfFrame pulses -> game_active=1 after 60th, not after 59th; ball_lost during RESPAWN leaves lives=2.
REQ-032 Three ball_lost pulses with respawns between -> lives=0, state LOSE, win=0; start_game -> lives=3, PLAY.
REQ-033 bricks_left=1, lives=1, brick_hit and ball_lost same cycle -> win=1, lives=0 not shown as lose only if win priority holds: required win=1, state WIN.
REQ-034 resetN pulsed low during RESPAWN -> immediately lives=3, bricks_left=40, freeze=1, game_active=0; startOfFrame pulses afterward cause no transition.
